// File: rtl/dtack_ctrl_pkg.sv
// Shared types and sizing helper for the 68000 DTACK wait-state controller.
package dtack_ctrl_pkg;

   typedef enum logic [2:0] {
      RECOVER,
      IDLE,
      WAIT_CNT,
      WAIT_EXT,
      ACK,
      BERR
   } state_t;

   typedef enum logic [1:0] {
      SRC_FAST,
      SRC_FLASH,
      SRC_DRAM,
      SRC_CAN
   } source_t;

   localparam int unsigned TIMEOUT_COUNT_W = 8;

   // Wide enough to hold the larger of the two terminal counts.
   function automatic int unsigned counterWidth(input int unsigned flashWait,
                                                input int unsigned timeoutCycles);
      int unsigned maxVal;
      maxVal = (flashWait > timeoutCycles) ? flashWait : timeoutCycles;
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/dtack_wait_controller_bus_cycle_timer.sv
// Loadable incrementing cycle counter with an equality compare against a terminal value.
module bus_cycle_timer #(
   parameter int unsigned W = 8
) (
   input  logic         Clock,
   input  logic         Reset_H,
   input  logic         Load,
   input  logic         Inc,
   input  logic [W-1:0] LoadValue,
   input  logic [W-1:0] CompareValue,
   output logic         Match_c
);

   logic [W-1:0] count;

   always_ff @(posedge Clock) begin
      if (Reset_H)
         count <= '0;
      else if (Load)
         count <= LoadValue;
      else if (Inc)
         count <= count + W'(1);
   end

   assign Match_c = (count == CompareValue);

endmodule

// File: rtl/dtack_wait_controller.sv
// Sequential DTACK source selection for the 68000: immediate, Flash wait states,
// or device dtack guarded by a bus-error watchdog with sticky error statistics.
module dtack_wait_controller
   import dtack_ctrl_pkg::*;
#(
   parameter int unsigned FLASH_WAIT     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                       Clock,
   input  logic                       Reset_H,
   input  logic                       AS_L,
   input  logic                       DramSelect_H,
   input  logic                       DramDtack_L,
   input  logic                       CanBusSelect_H,
   input  logic                       CanBusDtack_L,
   input  logic                       FlashSelect_H,
   output logic                       DtackOut_L,
   output logic                       BErrOut_L,
   output logic                       TimeoutSeen_H,
   output logic [TIMEOUT_COUNT_W-1:0] TimeoutCount
);

   localparam int unsigned CW = counterWidth(FLASH_WAIT, TIMEOUT_CYCLES);
   localparam logic FLASH_HAS_WAIT = (FLASH_WAIT != 0);

   state_t  state;
   source_t source;

   logic          startExt_c;
   logic          startFlash_c;
   logic          extDtackL_c;
   logic          timerLoad_c;
   logic          timerInc_c;
   logic          timerMatch_c;
   logic [CW-1:0] compareValue_c;

   assign startExt_c   = DramSelect_H | CanBusSelect_H;
   assign startFlash_c = FlashSelect_H & FLASH_HAS_WAIT;
   assign extDtackL_c  = (source == SRC_DRAM) ? DramDtack_L : CanBusDtack_L;

   assign compareValue_c = (source == SRC_FLASH) ? CW'(FLASH_WAIT) : CW'(TIMEOUT_CYCLES);

   // Counter is compared before incrementing, so it stops at the terminal value.
   assign timerLoad_c = (state == IDLE) & ~AS_L & (startExt_c | startFlash_c);
   assign timerInc_c  = ~AS_L & ~timerMatch_c &
                        ((state == WAIT_CNT) | ((state == WAIT_EXT) & extDtackL_c));

   bus_cycle_timer #(.W(CW)) uTimer (
      .Clock        (Clock),
      .Reset_H      (Reset_H),
      .Load         (timerLoad_c),
      .Inc          (timerInc_c),
      .LoadValue    (CW'(1)),
      .CompareValue (compareValue_c),
      .Match_c      (timerMatch_c)
   );

   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         state         <= RECOVER;
         source        <= SRC_FAST;
         DtackOut_L    <= 1'b1;
         BErrOut_L     <= 1'b1;
         TimeoutSeen_H <= 1'b0;
         TimeoutCount  <= '0;
      end else begin
         case (state)
            RECOVER: begin
               if (AS_L)
                  state <= IDLE;
            end
            IDLE: begin
               if (!AS_L) begin
                  if (DramSelect_H) begin
                     source <= SRC_DRAM;
                     state  <= WAIT_EXT;
                  end else if (CanBusSelect_H) begin
                     source <= SRC_CAN;
                     state  <= WAIT_EXT;
                  end else if (startFlash_c) begin
                     source <= SRC_FLASH;
                     state  <= WAIT_CNT;
                  end else begin
                     source     <= SRC_FAST;
                     state      <= ACK;
                     DtackOut_L <= 1'b0;
                  end
               end
            end
            WAIT_CNT: begin
               if (AS_L) begin
                  state <= IDLE;
               end else if (timerMatch_c) begin
                  state      <= ACK;
                  DtackOut_L <= 1'b0;
               end
            end
            WAIT_EXT: begin
               // Abort first, then dtack wins over a coincident timeout.
               if (AS_L) begin
                  state <= IDLE;
               end else if (!extDtackL_c) begin
                  state      <= ACK;
                  DtackOut_L <= 1'b0;
               end else if (timerMatch_c) begin
                  state         <= BERR;
                  BErrOut_L     <= 1'b0;
                  TimeoutSeen_H <= 1'b1;
                  if (TimeoutCount != '1)
                     TimeoutCount <= TimeoutCount + TIMEOUT_COUNT_W'(1);
               end
            end
            ACK, BERR: begin
               if (AS_L) begin
                  state      <= IDLE;
                  DtackOut_L <= 1'b1;
                  BErrOut_L  <= 1'b1;
               end
            end
            default: begin
               state      <= RECOVER;
               DtackOut_L <= 1'b1;
               BErrOut_L  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dtack_wait_controller.sv
// Bench for dtack_wait_controller: per-bus-cycle outcome model (which edge acks,
// times out or aborts) driving directed and randomized 68k bus cycles.
module tb_dtack_wait_controller;

   localparam int unsigned FW = 3;
   localparam int unsigned TO = 8;

   localparam int KIND_FAST  = 0;
   localparam int KIND_FLASH = 1;
   localparam int KIND_DRAM  = 2;
   localparam int KIND_CAN   = 3;

   logic       Clock = 1'b0;
   logic       Reset_H;
   logic       AS_L;
   logic       DramSelect_H;
   logic       DramDtack_L;
   logic       CanBusSelect_H;
   logic       CanBusDtack_L;
   logic       FlashSelect_H;
   logic       DtackOut_L;
   logic       BErrOut_L;
   logic       TimeoutSeen_H;
   logic [7:0] TimeoutCount;

   int compared   = 0;
   int mismatched = 0;
   int expCount   = 0;
   bit expSeen    = 1'b0;

   dtack_wait_controller #(.FLASH_WAIT(FW), .TIMEOUT_CYCLES(TO)) dut (
      .Clock          (Clock),
      .Reset_H        (Reset_H),
      .AS_L           (AS_L),
      .DramSelect_H   (DramSelect_H),
      .DramDtack_L    (DramDtack_L),
      .CanBusSelect_H (CanBusSelect_H),
      .CanBusDtack_L  (CanBusDtack_L),
      .FlashSelect_H  (FlashSelect_H),
      .DtackOut_L     (DtackOut_L),
      .BErrOut_L      (BErrOut_L),
      .TimeoutSeen_H  (TimeoutSeen_H),
      .TimeoutCount   (TimeoutCount)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic expDt, input logic expBe);
      check({tag, ".dtack"}, {7'd0, DtackOut_L}, {7'd0, expDt});
      check({tag, ".berr"}, {7'd0, BErrOut_L}, {7'd0, expBe});
      check({tag, ".seen"}, {7'd0, TimeoutSeen_H}, {7'd0, expSeen});
      check({tag, ".count"}, TimeoutCount, 8'(expCount));
   endtask

   // One clock: inputs already driven, sample at the following falling edge.
   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // One bus cycle. m = first edge offset the latched device drives dtack low;
   // r = edge offset where AS_L is first sampled high; gap = extra idle edges.
   task automatic runCycle(input string tag, input int kind, input int m,
                           input int r, input int gap);
      int  outcome;
      bit  isBerr;
      bit  happens;
      logic expDt;
      logic expBe;
      isBerr  = 1'b0;
      outcome = 0;
      if (kind == KIND_FLASH)
         outcome = FW;
      else if (kind == KIND_DRAM || kind == KIND_CAN) begin
         if (m <= int'(TO))
            outcome = (m < 1) ? 1 : m;
         else begin
            outcome = TO;
            isBerr  = 1'b1;
         end
      end
      happens = (outcome < r);
      for (int j = 0; j <= r + gap; j++) begin
         AS_L = (j < r) ? 1'b0 : 1'b1;
         if (j == 0) begin
            DramSelect_H   = (kind == KIND_DRAM);
            CanBusSelect_H = (kind == KIND_CAN);
            FlashSelect_H  = (kind == KIND_FLASH) ? 1'b1 :
                             (kind == KIND_CAN) ? 1'($urandom_range(1, 0)) : 1'b0;
            if (kind == KIND_DRAM) CanBusSelect_H = 1'($urandom_range(1, 0));
         end else begin
            DramSelect_H   = 1'($urandom_range(1, 0));
            CanBusSelect_H = 1'($urandom_range(1, 0));
            FlashSelect_H  = 1'($urandom_range(1, 0));
         end
         DramDtack_L   = 1'($urandom_range(1, 0));
         CanBusDtack_L = 1'($urandom_range(1, 0));
         if (kind == KIND_DRAM) DramDtack_L   = (j >= m) ? 1'b0 : 1'b1;
         if (kind == KIND_CAN)  CanBusDtack_L = (j >= m) ? 1'b0 : 1'b1;
         tick();
         if (happens && isBerr && j == outcome) begin
            expSeen = 1'b1;
            if (expCount < 255) expCount++;
         end
         expDt = (happens && !isBerr && j >= outcome && j < r) ? 1'b0 : 1'b1;
         expBe = (happens &&  isBerr && j >= outcome && j < r) ? 1'b0 : 1'b1;
         checkAll($sformatf("%s.e%0d", tag, j), expDt, expBe);
      end
   endtask

   task automatic idleInputs();
      AS_L           = 1'b1;
      DramSelect_H   = 1'b0;
      CanBusSelect_H = 1'b0;
      FlashSelect_H  = 1'b0;
      DramDtack_L    = 1'b1;
      CanBusDtack_L  = 1'b1;
   endtask

   initial begin
      int kind;
      int m;
      int r;
      int outc;

      // Reset while a bus cycle is pending: RECOVER must not acknowledge it.
      idleInputs();
      Reset_H     = 1'b1;
      AS_L        = 1'b0;
      DramDtack_L = 1'b0;
      tick();
      tick();
      checkAll("reset", 1'b1, 1'b1);
      Reset_H = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkAll($sformatf("recover%0d", i), 1'b1, 1'b1);
      end
      AS_L = 1'b1;
      tick();
      checkAll("recover_exit", 1'b1, 1'b1);

      // Directed cycles.
      runCycle("fast", KIND_FAST, 0, 2, 1);
      runCycle("flash", KIND_FLASH, 0, FW + 3, 0);
      runCycle("dram5", KIND_DRAM, 5, 8, 1);
      runCycle("can_to", KIND_CAN, TO + 5, TO + 2, 1);
      runCycle("dram_tie", KIND_DRAM, TO, TO + 2, 1);
      runCycle("abort_ext", KIND_DRAM, TO + 5, 3, 1);
      runCycle("abort_flash", KIND_FLASH, 0, FW, 1);
      runCycle("back2back", KIND_FAST, 0, 1, 0);

      // Reset mid-DRAM cycle clears statistics and suppresses the ack.
      AS_L         = 1'b0;
      DramSelect_H = 1'b1;
      DramDtack_L  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkAll($sformatf("midcyc%0d", i), 1'b1, 1'b1);
      end
      Reset_H     = 1'b1;
      DramDtack_L = 1'b0;
      tick();
      expCount = 0;
      expSeen  = 1'b0;
      checkAll("midreset", 1'b1, 1'b1);
      Reset_H = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkAll($sformatf("postreset%0d", i), 1'b1, 1'b1);
      end
      idleInputs();
      tick();
      checkAll("postreset_rel", 1'b1, 1'b1);
      runCycle("after_reset", KIND_DRAM, 2, 4, 1);

      // Saturation of the timeout counter.
      for (int i = 0; i < 256; i++)
         runCycle($sformatf("sat%0d", i), KIND_CAN, TO + 1, TO + 1, 0);
      check("saturated", TimeoutCount, 8'd255);

      // Randomized mix of devices, response times and aborts.
      for (int i = 0; i < 150; i++) begin
         kind = int'($urandom_range(3, 0));
         m    = int'($urandom_range(TO + 3, 1));
         outc = (kind == KIND_FAST) ? 0 : (kind == KIND_FLASH) ? FW :
                (m <= int'(TO)) ? m : TO;
         if (outc >= 1 && $urandom_range(5, 0) == 0)
            r = int'($urandom_range(outc, 1));
         else
            r = outc + 1 + int'($urandom_range(3, 0));
         runCycle($sformatf("rnd%0d", i), kind, m, r, int'($urandom_range(2, 0)));
      end

      // Final reset clears the saturated statistics.
      Reset_H = 1'b1;
      tick();
      Reset_H  = 1'b0;
      expCount = 0;
      expSeen  = 1'b0;
      checkAll("final_reset", 1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
